// File: rtl/audio_adc_pkg.sv
// Shared FSM state type and synchronizer depth for the audio ADC deserializer.
package audio_adc_pkg;

    localparam int unsigned SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        SYNC,
        DELAY,
        SHIFT,
        PAD
    } rx_state_e;

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous stereo-frame FIFO with full/empty flags; read data reads as zero while empty.
module audio_frame_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot a push into a full buffer needs.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/audio_adc_deserializer.sv
// I2S codec ADC deserializer: synchronizes BCLK/ADCLRCK/ADCDAT and buffers stereo frames.
// Define AUDIO_ADC_OVERFLOW_CNT_EN to add the saturating overflow_count output.
module audio_adc_deserializer #(
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ADCDAT,
    input  logic              ADCLRCK,
    input  logic              BCLK,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic              overflow
`ifdef AUDIO_ADC_OVERFLOW_CNT_EN
    ,
    output logic [15:0]       overflow_count
`endif
);
    import audio_adc_pkg::*;

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [SYNC_DEPTH-1:0] dat_sync;
    logic [SYNC_DEPTH-1:0] lrck_sync;
    logic [SYNC_DEPTH-1:0] bclk_sync;
    logic                  bclk_hist;
    logic                  dat_s;
    logic                  lrck_s;
    logic                  bclk_s;
    logic                  bclk_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            dat_sync  <= '0;
            lrck_sync <= '0;
            bclk_sync <= '0;
            bclk_hist <= 1'b0;
        end else begin
            dat_sync  <= {dat_sync[SYNC_DEPTH-2:0], ADCDAT};
            lrck_sync <= {lrck_sync[SYNC_DEPTH-2:0], ADCLRCK};
            bclk_sync <= {bclk_sync[SYNC_DEPTH-2:0], BCLK};
            bclk_hist <= bclk_sync[SYNC_DEPTH-1];
        end
    end

    assign dat_s     = dat_sync[SYNC_DEPTH-1];
    assign lrck_s    = lrck_sync[SYNC_DEPTH-1];
    assign bclk_s    = bclk_sync[SYNC_DEPTH-1];
    assign bclk_rise = bclk_s && !bclk_hist;

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              chan_q, chan_d;
    logic              left_ok_q, left_ok_d;
    logic              lrck_last_q;
    logic              lrck_seen_q;
    logic              lrck_change;
    logic [CNT_W-1:0]  bit_pos;
    logic [DATA_W-1:0] shreg_next;
    logic              word_done;
    logic [DATA_W-1:0] word_val;
    logic [DATA_W-1:0] left_q;
    logic [DATA_W-1:0] right_q;
    logic              push_q;

    // Word select is compared against its value at the previous BCLK rise, not the previous clk.
    assign lrck_change = bclk_rise && lrck_seen_q && (lrck_s != lrck_last_q);
    // Bits land MSB-first into a cleared register, so short words come out left-justified.
    assign bit_pos     = CNT_W'(DATA_W - 1) - bit_cnt_q;
    assign shreg_next  = shreg_q | (DATA_W'(dat_s) << bit_pos);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        chan_d    = chan_q;
        word_done = 1'b0;
        word_val  = shreg_q;
        if (bclk_rise) begin
            if (lrck_change) begin
                if (state_q == SHIFT) begin
                    word_done = 1'b1;
                end
                state_d   = DELAY;
                chan_d    = lrck_s;
                bit_cnt_d = '0;
                shreg_d   = '0;
            end else begin
                unique case (state_q)
                    SYNC:  state_d = SYNC;
                    DELAY: state_d = SHIFT;
                    SHIFT: begin
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            word_done = 1'b1;
                            word_val  = shreg_next;
                            state_d   = PAD;
                        end else begin
                            shreg_d   = shreg_next;
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    PAD:     state_d = PAD;
                    default: state_d = SYNC;
                endcase
            end
        end
    end

    always_comb begin
        left_ok_d = left_ok_q;
        if (state_q == SYNC) begin
            left_ok_d = 1'b0;
        end else if (word_done && !chan_q) begin
            left_ok_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SYNC;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            chan_q      <= 1'b0;
            left_ok_q   <= 1'b0;
            lrck_last_q <= 1'b0;
            lrck_seen_q <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            push_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            chan_q    <= chan_d;
            left_ok_q <= left_ok_d;
            if (bclk_rise) begin
                lrck_last_q <= lrck_s;
                lrck_seen_q <= 1'b1;
            end
            if (word_done && !chan_q) begin
                left_q <= word_val;
            end
            if (word_done && chan_q) begin
                right_q <= word_val;
            end
            push_q <= word_done && chan_q && left_ok_q;
        end
    end

    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [2*DATA_W-1:0]     fifo_data;
    logic                    frame_drop;
    logic                    overflow_q;

    audio_frame_fifo #(
        .WIDTH(2 * DATA_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_q),
        .push_data({left_q, right_q}),
        .pop      (fifo_pop),
        .pop_data (fifo_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign fifo_pop   = out_valid && out_ready;
    assign frame_drop = push_q && fifo_full && !fifo_pop;
    assign {out_left, out_right} = fifo_data;
    assign overflow   = overflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (frame_drop) begin
            overflow_q <= 1'b1;
        end
    end

`ifdef AUDIO_ADC_OVERFLOW_CNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_cnt_q <= '0;
        end else if (frame_drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign overflow_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_audio_adc_deserializer.sv
// Self-checking bench for audio_adc_deserializer: I2S serializer, frame scoreboard, corner cases.
module tb_audio_adc_deserializer;
    localparam int unsigned DATA_W     = 24;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned SLOT       = 32;
    localparam int unsigned HALF_BCLK  = 30;

    logic              clk = 1'b0;
    logic              reset;
    logic              ADCDAT;
    logic              ADCLRCK;
    logic              BCLK;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_left;
    logic [DATA_W-1:0] out_right;
    logic              overflow;
`ifdef AUDIO_ADC_OVERFLOW_CNT_EN
    logic [15:0]       overflow_count;
`endif

    audio_adc_deserializer #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ADCDAT        (ADCDAT),
        .ADCLRCK       (ADCLRCK),
        .BCLK          (BCLK),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_left      (out_left),
        .out_right     (out_right),
        .overflow      (overflow)
`ifdef AUDIO_ADC_OVERFLOW_CNT_EN
        ,
        .overflow_count(overflow_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } frame_t;

    typedef struct {
        logic [31:0]       l_raw;
        logic [31:0]       r_raw;
        int                nbits;
        logic [DATA_W-1:0] exp_l;
        logic [DATA_W-1:0] exp_r;
    } vec_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    frame_t exp_q[$];

    int  edge_cnt = 0;
    int  mark_edge = 0;
    int  mark_seq = 0;
    int  rshift_seq = 0;
    bit  lat_en = 1'b0;
    bit  lat_armed = 1'b0;
    bit  short_right_pending = 1'b0;
    logic last_ws = 1'b1;
    bit  rand_ready = 1'b0;
    int  valid_cycles = 0;

    logic              valid_prev = 1'b0;
    logic              ready_prev = 1'b0;
    logic [DATA_W-1:0] held_l = '0;
    logic [DATA_W-1:0] held_r = '0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a word of nbits is left-justified into DATA_W with zero LSBs.
    function automatic logic [DATA_W-1:0] ljust(input logic [31:0] val, input int nbits);
        logic [63:0] v;
        v = 64'(val) & ((64'd1 << nbits) - 64'd1);
        return DATA_W'(v << (DATA_W - nbits));
    endfunction

    // One BCLK period: drive data/word select after the falling edge, then rise, then fall.
    task automatic bit_period(input logic ws, input logic d, input bit complete, input bit rmark);
        ADCLRCK = ws;
        ADCDAT  = d;
        #(HALF_BCLK);
        BCLK = 1'b1;
        if (complete) begin
            mark_edge = edge_cnt;
            mark_seq++;
            if (lat_en) lat_armed = 1'b1;
        end
        if (rmark) rshift_seq++;
        #(HALF_BCLK);
        BCLK = 1'b0;
        last_ws = ws;
    endtask

    // I2S slot: change period, one delay period, nbits MSB-first, then random padding.
    task automatic send_word(input logic ws, input logic [31:0] val, input int nbits);
        int slot;
        slot = (nbits == int'(DATA_W)) ? int'(SLOT) : nbits + 2;
        for (int j = 0; j < slot; j++) begin
            logic d;
            bit   comp;
            d    = 1'($urandom_range(0, 1));
            comp = (j == 0) && short_right_pending && (ws != last_ws);
            if (j >= 2 && j < 2 + nbits) d = val[nbits - 1 - (j - 2)];
            if (ws && nbits == int'(DATA_W) && j == nbits + 1) comp = 1'b1;
            bit_period(ws, d, comp, ws && (j == 12));
        end
        short_right_pending = ws && (nbits < int'(DATA_W));
    endtask

    task automatic send_idle(input logic ws, input int n);
        for (int j = 0; j < n; j++) begin
            bit comp;
            comp = (j == 0) && short_right_pending && (ws != last_ws);
            bit_period(ws, 1'($urandom_range(0, 1)), comp, 1'b0);
        end
        short_right_pending = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        lat_armed = 1'b0;
        short_right_pending = 1'b0;
        // Keep BCLK edges away from clk edges.
        @(posedge clk);
        #7;
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 4000 && exp_q.size() != 0; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    always begin
        @(negedge clk);
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard: every handshake pops the next expected frame.
    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            valid_prev = 1'b0;
        end else begin
            if (valid_prev && !ready_prev && out_valid) begin
                check("hold_left", 64'(out_left), 64'(held_l));
                check("hold_right", 64'(out_right), 64'(held_r));
            end
            if (out_valid && !valid_prev && lat_armed) begin
                check("push_to_valid_latency", 64'(edge_cnt - mark_edge), 64'd4);
                lat_armed = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got L=0x%0h R=0x%0h, required none",
                             out_left, out_right);
                end else begin
                    frame_t f;
                    f = exp_q.pop_front();
                    check("frame_left", 64'(out_left), 64'(f.l));
                    check("frame_right", 64'(out_right), 64'(f.r));
                end
            end
            if (out_valid) valid_cycles++;
            valid_prev = out_valid;
        end
        ready_prev = out_ready;
        held_l     = out_left;
        held_r     = out_right;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   vecs[5];
        frame_t fr[5];
        int     base;

        vecs[0] = '{32'h123456, 32'hABCDEF, 24, 24'h123456, 24'hABCDEF};
        vecs[1] = '{32'h8001,   32'h7FFE,   16, 24'h800100, 24'h7FFE00};
        vecs[2] = '{32'hFFFFFF, 32'h000001, 24, 24'hFFFFFF, 24'h000001};
        vecs[3] = '{32'hABCDE,  32'h12345,  20, 24'hABCDE0, 24'h123450};
        vecs[4] = '{32'h800000, 32'h7FFFFF, 24, 24'h800000, 24'h7FFFFF};

        reset     = 1'b1;
        ADCDAT    = 1'b0;
        ADCLRCK   = 1'b1;
        BCLK      = 1'b0;
        out_ready = 1'b1;
        do_reset();

        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_left", 64'(out_left), 64'd0);
        check("reset_right", 64'(out_right), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
`ifdef AUDIO_ADC_OVERFLOW_CNT_EN
        check("reset_overflow_count", 64'(overflow_count), 64'd0);
`endif

        // BCLK running, word select static: nothing may come out.
        valid_cycles = 0;
        send_idle(1'b1, 40);
        repeat (10) @(negedge clk);
        check("static_lrck_no_frame", 64'(valid_cycles), 64'd0);

        // Table of full and short frames with consumer always ready.
        do_reset();
        lat_en = 1'b1;
        send_idle(1'b1, 4);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{l: vecs[i].exp_l, r: vecs[i].exp_r});
            send_word(1'b0, vecs[i].l_raw, vecs[i].nbits);
            send_word(1'b1, vecs[i].r_raw, vecs[i].nbits);
        end
        send_idle(1'b0, 4);
        wait_drain("table_drain");
        lat_en = 1'b0;

        // Five frames into a stalled consumer: the fifth is dropped.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) fr[i] = '{l: DATA_W'($urandom), r: DATA_W'($urandom)};
        send_idle(1'b1, 4);
        for (int i = 0; i < 5; i++) begin
            send_word(1'b0, 32'(fr[i].l), 24);
            send_word(1'b1, 32'(fr[i].r), 24);
        end
        send_idle(1'b0, 4);
        repeat (10) @(negedge clk);
        check("ovf_flag", 64'(overflow), 64'd1);
`ifdef AUDIO_ADC_OVERFLOW_CNT_EN
        check("ovf_count", 64'(overflow_count), 64'd1);
`endif
        check("ovf_valid_held", 64'(out_valid), 64'd1);
        check("ovf_head_left", 64'(out_left), 64'(fr[0].l));
        check("ovf_head_right", 64'(out_right), 64'(fr[0].r));
        for (int i = 0; i < 4; i++) exp_q.push_back(fr[i]);
        out_ready = 1'b1;
        wait_drain("ovf_drain");
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Full FIFO with a pop in the very cycle the fifth frame is pushed.
        do_reset();
        out_ready = 1'b0;
        base = mark_seq;
        for (int i = 0; i < 5; i++) begin
            fr[i] = '{l: DATA_W'($urandom), r: DATA_W'($urandom)};
            exp_q.push_back(fr[i]);
        end
        fork
            begin
                send_idle(1'b1, 4);
                for (int i = 0; i < 5; i++) begin
                    send_word(1'b0, 32'(fr[i].l), 24);
                    send_word(1'b1, 32'(fr[i].r), 24);
                end
                send_idle(1'b0, 4);
            end
            begin
                for (int c = 0; c < 20000 && mark_seq < base + 5; c++) @(negedge clk);
                if (mark_seq < base + 5) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL fifth_frame_timeout: got %0d words, required 5", mark_seq - base);
                end else begin
                    while (edge_cnt < mark_edge + 3) @(negedge clk);
                    out_ready = 1'b1;
                    @(negedge clk);
                    out_ready = 1'b0;
                end
            end
        join
        repeat (10) @(negedge clk);
        check("full_pushpop_no_overflow", 64'(overflow), 64'd0);
        check("full_pushpop_remaining", 64'(exp_q.size()), 64'd4);
        out_ready = 1'b1;
        wait_drain("full_pushpop_drain");
        check("full_pushpop_overflow_after", 64'(overflow), 64'd0);

        // Reset during the right word: that frame is lost, the next pair comes through.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) fr[i] = '{l: DATA_W'($urandom), r: DATA_W'($urandom)};
        exp_q.push_back('{l: fr[2].l, r: fr[3].r});
        base = rshift_seq;
        fork
            begin
                send_idle(1'b1, 4);
                send_word(1'b0, 32'(fr[0].l), 24);
                send_word(1'b1, 32'(fr[1].r), 24);
                send_word(1'b0, 32'(fr[2].l), 24);
                send_word(1'b1, 32'(fr[3].r), 24);
                send_idle(1'b0, 4);
            end
            begin
                for (int c = 0; c < 20000 && rshift_seq == base; c++) @(negedge clk);
                reset = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
            end
        join
        wait_drain("midreset_drain");
        check("midreset_overflow", 64'(overflow), 64'd0);

        // Random words of random length against the left-justify model, random back-pressure.
        do_reset();
        rand_ready = 1'b1;
        send_idle(1'b1, 4);
        for (int i = 0; i < 12; i++) begin
            int          nl;
            int          nr;
            logic [31:0] vl;
            logic [31:0] vr;
            nl = int'($urandom_range(16, DATA_W));
            nr = int'($urandom_range(16, DATA_W));
            vl = $urandom;
            vr = $urandom;
            exp_q.push_back('{l: ljust(vl, nl), r: ljust(vr, nr)});
            send_word(1'b0, vl, nl);
            send_word(1'b1, vr, nr);
        end
        send_idle(1'b0, 4);
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        wait_drain("random_drain");
        check("random_overflow", 64'(overflow), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
